// File: rtl/pio_edge_irq_in_pkg.sv
// Shared constants for the edge-capturing input PIO.
//   - Slave register addresses (2-bit word address).
//   - Edge-type encodings for the EDGE_TYPE parameter.
//   - Helpers that size the per-pin debounce counter.
package pio_edge_irq_pkg;

    localparam logic [1:0] ADDR_DATA     = 2'd0;
    localparam logic [1:0] ADDR_IRQ_MASK = 2'd1;
    localparam logic [1:0] ADDR_EDGE_CAP = 2'd2;
    localparam logic [1:0] ADDR_RSVD     = 2'd3;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

    // Number of consecutive differing cycles needed to accept a change.
    // A setting of 0 is treated the same as 1.
    function automatic int debounce_threshold(input int cycles);
        return (cycles < 1) ? 1 : cycles;
    endfunction

    // Counter width: $clog2(cycles+1), never less than one bit.
    function automatic int debounce_cnt_width(input int cycles);
        return (cycles < 1) ? 1 : $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/pio_edge_irq_in_debounce.sv
// Per-pin input conditioning: two-flop synchronizer, debounce counter and
// stable register.
// Ports:
//   clk, reset_n  system clock, asynchronous active-low reset
//   pin           raw asynchronous input pin
//   stable        debounced pin value
//   update        high for the cycle whose rising clk edge flips stable
module pio_in_bit_sync_debounce
    import pio_edge_irq_pkg::*;
#(
    parameter int   DEBOUNCE_CYCLES = 0,
    parameter logic RESET_VALUE     = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic pin,
    output logic stable,
    output logic update
);

    localparam int                THRESHOLD = debounce_threshold(DEBOUNCE_CYCLES);
    localparam int                CNT_W     = debounce_cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(THRESHOLD - 1);

    logic             s1;
    logic             s2;
    logic [CNT_W-1:0] cnt;
    logic             differs;

    assign differs = (s2 != stable);
    // Combinational so the top can capture the edge on the same clock edge
    // that stable changes.
    assign update  = differs && (cnt == CNT_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1     <= RESET_VALUE;
            s2     <= RESET_VALUE;
            stable <= RESET_VALUE;
            cnt    <= '0;
        end else begin
            s1 <= pin;
            s2 <= s1;
            // cnt never passes CNT_LAST: reaching it either accepts the
            // change or the input has returned, both of which clear it.
            if (!differs || update) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
            if (update) begin
                stable <= s2;
            end
        end
    end

endmodule

// File: rtl/pio_edge_irq_in.sv
// Avalon-MM input PIO with debounced pins, edge capture and level interrupt.
// Ports:
//   clk, reset_n   system clock, asynchronous active-low reset
//   address        register select (0 DATA, 1 IRQ_MASK, 2 EDGE_CAPTURE, 3 reserved)
//   chipselect     slave select
//   write_n        active-low write strobe
//   writedata      write data
//   in_port        asynchronous external pins
//   readdata       zero-wait-state read data, combinational from address
//   irq            active-high level interrupt
module pio_edge_irq_in
    import pio_edge_irq_pkg::*;
#(
    parameter int               WIDTH           = 8,
    parameter int               DEBOUNCE_CYCLES = 0,
    parameter int               EDGE_TYPE       = 0,
    parameter logic [WIDTH-1:0] IN_RESET_VALUE  = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    logic [WIDTH-1:0] stable;
    logic [WIDTH-1:0] update;
    logic [WIDTH-1:0] edge_hit;
    logic [WIDTH-1:0] cap_clear;
    logic [WIDTH-1:0] irq_mask;
    logic [WIDTH-1:0] edge_capture;
    logic             wr_en;
    logic             unused_writedata;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        pio_in_bit_sync_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .RESET_VALUE     (IN_RESET_VALUE[i])
        ) u_bit (
            .clk     (clk),
            .reset_n (reset_n),
            .pin     (in_port[i]),
            .stable  (stable[i]),
            .update  (update[i])
        );
    end

    // update implies stable is about to flip, so the current stable value
    // tells the direction of the edge.
    always_comb begin
        case (EDGE_TYPE)
            EDGE_RISE: edge_hit = update & ~stable;
            EDGE_FALL: edge_hit = update & stable;
            default:   edge_hit = update;
        endcase
    end

    assign wr_en            = chipselect && !write_n;
    assign cap_clear        = (wr_en && (address == ADDR_EDGE_CAP)) ? writedata[WIDTH-1:0] : '0;
    assign unused_writedata = ^writedata;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_mask     <= '0;
            edge_capture <= '0;
        end else begin
            if (wr_en && (address == ADDR_IRQ_MASK)) begin
                irq_mask <= writedata[WIDTH-1:0];
            end
            // A new edge is ORed in after the clear so it survives a
            // simultaneous W1C of the same bit.
            edge_capture <= (edge_capture & ~cap_clear) | edge_hit;
        end
    end

    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA:     readdata[WIDTH-1:0] = stable;
            ADDR_IRQ_MASK: readdata[WIDTH-1:0] = irq_mask;
            ADDR_EDGE_CAP: readdata[WIDTH-1:0] = edge_capture;
            default:       readdata = '0;
        endcase
    end

    assign irq = |(edge_capture & irq_mask);

endmodule
